// File: rtl/fsm_pkg.sv
// Constants shared by the serial feeder and the "111" detector.
// Holds the FSM state encodings, the default word width and the bit-index width helper.
package fsm_pkg;

  // Feeder state encoding
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] GAP   = 2'b10;

  // Detector state encoding: number of consecutive ones seen, saturating at three
  localparam logic [1:0] DET_S0 = 2'b00;
  localparam logic [1:0] DET_S1 = 2'b01;
  localparam logic [1:0] DET_S2 = 2'b10;
  localparam logic [1:0] DET_S3 = 2'b11;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int BIT_IDX_W(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/par2ser_feeder_piso.sv
// Parallel-in / serial-out shift register with selectable transmit order.
// A load takes priority over a shift, so a word can be reloaded on the last-bit edge.
module piso_shreg
  import fsm_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             head
);

  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shreg_reg[WIDTH-2:0], 1'b0};
      assign head    = shreg_reg[WIDTH-1];
    end else begin : g_lsb_first
      assign shifted = {1'b0, shreg_reg[WIDTH-1:1]};
      assign head    = shreg_reg[0];
    end
  endgenerate

  always_comb begin
    shreg_next = shreg_reg;
    if (load) begin
      shreg_next = data_in;
    end else if (shift) begin
      shreg_next = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_reg <= '0;
    end else begin
      shreg_reg <= shreg_next;
    end
  end

endmodule

// File: rtl/par2ser_feeder.sv
// Accepts parallel words on a valid/ready handshake and streams them one bit per clock
// to the serial detector, with optional idle-zero gap cycles between words.
module par2ser_feeder
  import fsm_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           data_valid,
  output logic                           data_ready,
  output logic                           ser_out,
  output logic                           ser_valid,
  output logic                           word_done,
  output logic [BIT_IDX_W(WIDTH)-1:0]    bit_idx,
  output logic                           busy
);

  localparam int             BW       = BIT_IDX_W(WIDTH);
  localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
  localparam bit             HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [7:0]     GAP_LAST = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [BW-1:0] bit_cnt_reg;
  logic [BW-1:0] bit_cnt_next;
  logic [7:0]    gap_cnt_reg;
  logic [7:0]    gap_cnt_next;
  logic          head;
  logic          accept;
  logic          shift;
  logic          bit_last;
  logic          gap_last;

  assign bit_last = (bit_cnt_reg == BIT_LAST);
  assign gap_last = (gap_cnt_reg == GAP_LAST);
  assign accept   = data_valid & data_ready;
  assign shift    = (state_reg == SHIFT) & ~accept;

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .shift   (shift),
    .data_in (data_in),
    .head    (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  // Counters default to zero so every state exit clears them.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = '0;
    gap_cnt_next = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_last) begin
          if (HAS_GAP) begin
            state_next = GAP;
          end else if (accept) begin
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Serial outputs decode from state and registers only; data_ready is held low during reset.
  always_comb begin
    data_ready = 1'b0;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    word_done  = 1'b0;
    bit_idx    = '0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        data_ready = rst;
      end
      SHIFT: begin
        ser_valid  = 1'b1;
        ser_out    = head;
        bit_idx    = bit_cnt_reg;
        word_done  = bit_last;
        data_ready = rst & bit_last & ~HAS_GAP;
      end
      default: begin
        data_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_par2ser_feeder.sv
// Directed bench for par2ser_feeder: four instances cover gapless MSB-first, LSB-first,
// and two gap lengths; each cycle compares a packed snapshot of all outputs.
module tb_par2ser_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A: MSB first, no gap
  logic [7:0] data_a = 8'h00;
  logic       valid_a = 1'b0;
  logic       ready_a, sout_a, sval_a, wd_a, busy_a;
  logic [2:0] idx_a;
  // Instance L: LSB first, no gap
  logic [7:0] data_l = 8'h00;
  logic       valid_l = 1'b0;
  logic       ready_l, sout_l, sval_l, wd_l, busy_l;
  logic [2:0] idx_l;
  // Instance G3: MSB first, 3 gap cycles
  logic [7:0] data_g3 = 8'h00;
  logic       valid_g3 = 1'b0;
  logic       ready_g3, sout_g3, sval_g3, wd_g3, busy_g3;
  logic [2:0] idx_g3;
  // Instance G2: MSB first, 2 gap cycles
  logic [7:0] data_g2 = 8'h00;
  logic       valid_g2 = 1'b0;
  logic       ready_g2, sout_g2, sval_g2, wd_g2, busy_g2;
  logic [2:0] idx_g2;

  par2ser_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .data_valid(valid_a), .data_ready(ready_a),
    .ser_out(sout_a), .ser_valid(sval_a), .word_done(wd_a), .bit_idx(idx_a), .busy(busy_a));
  par2ser_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_l), .data_valid(valid_l), .data_ready(ready_l),
    .ser_out(sout_l), .ser_valid(sval_l), .word_done(wd_l), .bit_idx(idx_l), .busy(busy_l));
  par2ser_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) dut_g3 (
    .clk(clk), .rst(rst), .data_in(data_g3), .data_valid(valid_g3), .data_ready(ready_g3),
    .ser_out(sout_g3), .ser_valid(sval_g3), .word_done(wd_g3), .bit_idx(idx_g3), .busy(busy_g3));
  par2ser_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_g2 (
    .clk(clk), .rst(rst), .data_in(data_g2), .data_valid(valid_g2), .data_ready(ready_g2),
    .ser_out(sout_g2), .ser_valid(sval_g2), .word_done(wd_g2), .bit_idx(idx_g2), .busy(busy_g2));

  // Snapshot layout: {data_ready, busy, ser_valid, ser_out, word_done, bit_idx[2:0]}
  wire [7:0] obs_a  = {ready_a,  busy_a,  sval_a,  sout_a,  wd_a,  idx_a};
  wire [7:0] obs_l  = {ready_l,  busy_l,  sval_l,  sout_l,  wd_l,  idx_l};
  wire [7:0] obs_g3 = {ready_g3, busy_g3, sval_g3, sout_g3, wd_g3, idx_g3};
  wire [7:0] obs_g2 = {ready_g2, busy_g2, sval_g2, sout_g2, wd_g2, idx_g2};

  // Reference "111" detector on instance A's stream (overlapping matches count).
  int det_run  = 0;
  int det_hits = 0;
  int wd_count = 0;
  always @(negedge clk) begin
    if (sout_a) begin
      if (det_run < 3) det_run = det_run + 1;
      if (det_run == 3) det_hits = det_hits + 1;
    end else begin
      det_run = 0;
    end
    if (wd_a) wd_count = wd_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    #2;
    exp = 8'h00;
    vectors++;
    if (obs_a !== exp) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", obs_a, exp);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp = 8'h80;
    vectors++;
    if (obs_a !== exp) begin
      miscompares++;
      $display("FAIL reset_release_a: got %h expected %h", obs_a, exp);
    end
    vectors++;
    if (obs_g3 !== exp) begin
      miscompares++;
      $display("FAIL reset_release_g3: got %h expected %h", obs_g3, exp);
    end
  endtask

  task automatic test_single();
    logic [7:0] w = 8'hE0;
    logic [7:0] exp;
    int h0 = det_hits;
    data_a  = w;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    data_a  = 8'h00;
    for (int k = 0; k < 8; k++) begin
      exp = {k == 7, 1'b1, 1'b1, w[7-k], k == 7, 3'(k)};
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL single_bit%0d: got %h expected %h", k, obs_a, exp);
      end
      tick();
    end
    exp = 8'h80;
    vectors++;
    if (obs_a !== exp) begin
      miscompares++;
      $display("FAIL single_after: got %h expected %h", obs_a, exp);
    end
    tick();
    vectors++;
    if (det_hits - h0 !== 1) begin
      miscompares++;
      $display("FAIL single_hits: got %0d expected 1", det_hits - h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream = 16'h01C0;
    logic [7:0]  exp;
    int h0 = det_hits;
    data_a  = 8'h01;
    valid_a = 1'b1;
    tick();
    data_a = 8'hC0;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) valid_a = 1'b0;
      exp = {(k % 8) == 7, 1'b1, 1'b1, stream[15-k], (k % 8) == 7, 3'(k % 8)};
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL b2b_bit%0d: got %h expected %h", k, obs_a, exp);
      end
      tick();
    end
    exp = 8'h80;
    vectors++;
    if (obs_a !== exp) begin
      miscompares++;
      $display("FAIL b2b_after: got %h expected %h", obs_a, exp);
    end
    tick();
    vectors++;
    if (det_hits - h0 !== 1) begin
      miscompares++;
      $display("FAIL b2b_hits: got %0d expected 1", det_hits - h0);
    end
  endtask

  task automatic test_gap();
    logic [7:0] exp;
    data_g3  = 8'hFF;
    valid_g3 = 1'b1;
    tick();
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 8; k++) begin
        exp = {1'b0, 1'b1, 1'b1, 1'b1, k == 7, 3'(k)};
        vectors++;
        if (obs_g3 !== exp) begin
          miscompares++;
          $display("FAIL gap_w%0d_bit%0d: got %h expected %h", n, k, obs_g3, exp);
        end
        tick();
      end
      for (int g = 0; g < 3; g++) begin
        exp = 8'h40;
        vectors++;
        if (obs_g3 !== exp) begin
          miscompares++;
          $display("FAIL gap_w%0d_idle%0d: got %h expected %h", n, g, obs_g3, exp);
        end
        tick();
      end
      exp = 8'h80;
      vectors++;
      if (obs_g3 !== exp) begin
        miscompares++;
        $display("FAIL gap_w%0d_ready: got %h expected %h", n, obs_g3, exp);
      end
      if (n == 0) begin
        tick();
        valid_g3 = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_lsb();
    logic [7:0] w = 8'h07;
    logic [7:0] exp;
    data_l  = w;
    valid_l = 1'b1;
    tick();
    valid_l = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = {k == 7, 1'b1, 1'b1, w[k], k == 7, 3'(k)};
      vectors++;
      if (obs_l !== exp) begin
        miscompares++;
        $display("FAIL lsb_bit%0d: got %h expected %h", k, obs_l, exp);
      end
      tick();
    end
    exp = 8'h80;
    vectors++;
    if (obs_l !== exp) begin
      miscompares++;
      $display("FAIL lsb_after: got %h expected %h", obs_l, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w = 8'hA5;
    logic [7:0] exp;
    int wd0;
    data_a  = 8'hFF;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    tick();
    tick();
    tick();
    exp = 8'h73;
    vectors++;
    if (obs_a !== exp) begin
      miscompares++;
      $display("FAIL rstmid_before: got %h expected %h", obs_a, exp);
    end
    wd0 = wd_count;
    rst = 1'b0;
    #1;
    exp = 8'h00;
    vectors++;
    if (obs_a !== exp) begin
      miscompares++;
      $display("FAIL rstmid_async: got %h expected %h", obs_a, exp);
    end
    tick();
    tick();
    vectors++;
    if (obs_a !== exp) begin
      miscompares++;
      $display("FAIL rstmid_held: got %h expected %h", obs_a, exp);
    end
    rst = 1'b1;
    tick();
    exp = 8'h80;
    vectors++;
    if (obs_a !== exp) begin
      miscompares++;
      $display("FAIL rstmid_release: got %h expected %h", obs_a, exp);
    end
    vectors++;
    if (wd_count !== wd0) begin
      miscompares++;
      $display("FAIL rstmid_word_done: got %0d expected %0d", wd_count, wd0);
    end
    data_a  = w;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = {k == 7, 1'b1, 1'b1, w[7-k], k == 7, 3'(k)};
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL rstmid_a5_bit%0d: got %h expected %h", k, obs_a, exp);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [7:0] w0 = 8'h81;
    logic [7:0] w1 = 8'h3C;
    logic [7:0] exp;
    data_g2  = w0;
    valid_g2 = 1'b1;
    tick();
    valid_g2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        data_g2  = w1;
        valid_g2 = 1'b1;
      end
      exp = {1'b0, 1'b1, 1'b1, w0[7-k], k == 7, 3'(k)};
      vectors++;
      if (obs_g2 !== exp) begin
        miscompares++;
        $display("FAIL stall_w0_bit%0d: got %h expected %h", k, obs_g2, exp);
      end
      tick();
    end
    for (int g = 0; g < 2; g++) begin
      exp = 8'h40;
      vectors++;
      if (obs_g2 !== exp) begin
        miscompares++;
        $display("FAIL stall_gap%0d: got %h expected %h", g, obs_g2, exp);
      end
      tick();
    end
    exp = 8'h80;
    vectors++;
    if (obs_g2 !== exp) begin
      miscompares++;
      $display("FAIL stall_idle: got %h expected %h", obs_g2, exp);
    end
    tick();
    valid_g2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = {1'b0, 1'b1, 1'b1, w1[7-k], k == 7, 3'(k)};
      vectors++;
      if (obs_g2 !== exp) begin
        miscompares++;
        $display("FAIL stall_w1_bit%0d: got %h expected %h", k, obs_g2, exp);
      end
      tick();
    end
    tick();
    tick();
    exp = 8'h80;
    vectors++;
    if (obs_g2 !== exp) begin
      miscompares++;
      $display("FAIL stall_end: got %h expected %h", obs_g2, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_lsb();
    test_reset_mid();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
